// File: rtl/aes_pkg.sv
// aes_pkg: shared AES widths, GF(2^8) reduction constant, FSM state enum and xtime helper.
// No ports; imported by the interface, the column sub-module and the top.
package aes_pkg;
    localparam int STATE_W = 128;
    localparam int COL_W = 32;
    localparam int N_COLS = 4;
    localparam logic [7:0] RED_POLY = 8'h1B;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? RED_POLY : 8'h00);
    endfunction
endpackage

// File: rtl/inv_mix_columns_iter_if.sv
// inv_mix_columns_iter_if: valid/ready stream bus carrying one 128-bit AES state in and out.
// Signals: stateIn/inValid/inReady (input side), stateOut/outValid/outReady (output side).
// Modports: master drives stateIn/inValid/outReady, slave (the block) drives inReady/stateOut/outValid.
interface inv_mix_columns_iter_if;
    import aes_pkg::*;
    logic [STATE_W-1:0] stateIn;
    logic [STATE_W-1:0] stateOut;
    logic inValid;
    logic inReady;
    logic outValid;
    logic outReady;
    modport master (output stateIn, inValid, outReady, input inReady, stateOut, outValid);
    modport slave (input stateIn, inValid, outReady, output inReady, stateOut, outValid);
endinterface

// File: rtl/inv_mix_single_column.sv
// inv_mix_single_column: combinational InvMixColumns of one 32-bit column, xtime chains and XOR only.
// Ports: col_in (row-0 byte in [31:24]), col_out (same layout).
module inv_mix_single_column
    import aes_pkg::*;
(
    input  logic [COL_W-1:0] col_in,
    output logic [COL_W-1:0] col_out
);
    logic [7:0] s [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    for (genvar i = 0; i < 4; i++) begin : g_byte
        logic [7:0] x2, x4, x8;
        assign s[i]  = col_in[COL_W-1-8*i -: 8];
        assign x2    = xtime(s[i]);
        assign x4    = xtime(x2);
        assign x8    = xtime(x4);
        assign m9[i] = x8 ^ s[i];
        assign mb[i] = x8 ^ x2 ^ s[i];
        assign md[i] = x8 ^ x4 ^ s[i];
        assign me[i] = x8 ^ x4 ^ x2;
    end
    assign col_out = {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                      m9[0] ^ me[1] ^ mb[2] ^ md[3],
                      md[0] ^ m9[1] ^ me[2] ^ mb[3],
                      mb[0] ^ md[1] ^ m9[2] ^ me[3]};
endmodule

// File: rtl/inv_mix_columns_iter.sv
// inv_mix_columns_iter: iterative AES InvMixColumns, one column per cycle through a shared column unit.
// Ports: clk, rst_n (async active-low), bus (slave modport: stateIn/inValid/inReady in, stateOut/outValid/outReady out).
module inv_mix_columns_iter
    import aes_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    inv_mix_columns_iter_if.slave bus
);
    state_t state, state_nx;
    logic [1:0] col_cnt;
    logic [STATE_W-1:0] data_q;
    logic [STATE_W-1:0] state_out;
    logic [COL_W-1:0] col_in, col_out;
    assign col_in = data_q[{col_cnt, 5'b0} +: COL_W];
    inv_mix_single_column u_col (.col_in(col_in), .col_out(col_out));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = bus.inValid ? BUSY : IDLE;
            BUSY:    state_nx = (col_cnt == 2'(N_COLS - 1)) ? DONE : BUSY;
            DONE:    state_nx = bus.outReady ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end
    // inReady is gated by rst_n so it drops the instant reset asserts and rises as soon as it releases.
    always_comb begin
        bus.inReady  = (state == IDLE) && rst_n;
        bus.outValid = (state == DONE);
        bus.stateOut = state_out;
    end
    // col_cnt naturally wraps 3->0 on the same edge that leaves BUSY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_cnt   <= '0;
            data_q    <= '0;
            state_out <= '0;
        end else if (state == IDLE && bus.inValid) begin
            data_q  <= bus.stateIn;
            col_cnt <= '0;
        end else if (state == BUSY) begin
            state_out[{col_cnt, 5'b0} +: COL_W] <= col_out;
            col_cnt <= col_cnt + 2'd1;
        end
    end
endmodule

// File: tb/tb_inv_mix_columns_iter.sv
// tb_inv_mix_columns_iter: scoreboard bench for inv_mix_columns_iter (vectors, hold, reset, random round trip).
module tb_inv_mix_columns_iter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [127:0] exp_q [$];
    int acc_q [$];
    logic prev_ov = 1'b0;

    inv_mix_columns_iter_if bus();
    inv_mix_columns_iter dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] s0, s1, s2, s3;
        {s0, s1, s2, s3} = c;
        return {gmul(s0, 2) ^ gmul(s1, 3) ^ s2 ^ s3,
                s0 ^ gmul(s1, 2) ^ gmul(s2, 3) ^ s3,
                s0 ^ s1 ^ gmul(s2, 2) ^ gmul(s3, 3),
                gmul(s0, 3) ^ s1 ^ s2 ^ gmul(s3, 2)};
    endfunction

    function automatic logic [127:0] mix_state(input logic [127:0] x);
        logic [127:0] r;
        for (int i = 0; i < 4; i++) r[32*i +: 32] = mix_col(x[32*i +: 32]);
        return r;
    endfunction

    function automatic logic [127:0] rand_state();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Starts and ends on a negedge; acc is the cycle count right after the accept edge.
    task automatic send(input logic [127:0] s, input logic [127:0] e, output int acc);
        int n;
        n = 0;
        bus.stateIn = s;
        bus.inValid = 1'b1;
        while (!bus.inReady && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait", n < 20, 1);
        @(posedge clk);
        @(negedge clk);
        bus.inValid = 1'b0;
        bus.stateIn = ~s;
        acc = cyc;
        exp_q.push_back(e);
        acc_q.push_back(cyc);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("drain", exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.outValid && !prev_ov) begin
                if (acc_q.size() > 0) check("latency", cyc - acc_q[0], 4);
                else check("spurious_valid", bus.outValid, 0);
            end
            if (bus.outValid && bus.outReady) begin
                if (exp_q.size() > 0) begin
                    check("data", bus.stateOut, exp_q.pop_front());
                    void'(acc_q.pop_front());
                end else begin
                    check("spurious_out", bus.outValid, 0);
                end
            end
        end
        prev_ov = bus.outValid;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, last, n;
        logic [127:0] x, he;
        bus.stateIn = '0;
        bus.inValid = 1'b0;
        bus.outReady = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_inready", bus.inReady, 0);
        check("rst_outvalid", bus.outValid, 0);
        check("rst_stateout", bus.stateOut, 0);
        rst_n = 1'b1;
        #1;
        check("rel_inready", bus.inReady, 1);
        @(negedge clk);

        send(128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 128'hdb135345_f20a225c_01010101_c6c6c6c6, a);
        drain();
        send(128'hd5d5d7d6_4d7ebdf8_d5d5d7d6_4d7ebdf8, 128'hd4d4d4d5_2d26314c_d4d4d4d5_2d26314c, a);
        drain();

        x = rand_state();
        he = x;
        bus.outReady = 1'b0;
        send(mix_state(x), he, a);
        n = 0;
        while (!bus.outValid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("hold_reach", bus.outValid, 1);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                bus.stateIn = rand_state();
                bus.inValid = 1'b1;
            end
            if (i == 4) bus.inValid = 1'b0;
            @(negedge clk);
            check("hold_valid", bus.outValid, 1);
            check("hold_data", bus.stateOut, he);
            check("hold_inready", bus.inReady, 0);
        end
        bus.outReady = 1'b1;
        drain();
        repeat (8) @(negedge clk);

        x = rand_state();
        send(mix_state(x), x, a);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_outvalid", bus.outValid, 0);
        check("mid_rst_stateout", bus.stateOut, 0);
        check("mid_rst_inready", bus.inReady, 0);
        exp_q.delete();
        acc_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_inready", bus.inReady, 1);
        x = rand_state();
        send(mix_state(x), x, a);
        drain();

        last = 0;
        for (int k = 0; k < 1000; k++) begin
            x = rand_state();
            send(mix_state(x), x, a);
            if (k > 0) check("spacing", a - last, 6);
            last = a;
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
